// File: rtl/mat_add_pkg.sv
// Shared definitions for the streaming matrix adder: default sizes, FSM encoding
// and saturation limits for the signed result range.
package mat_add_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_N      = 4;
    localparam int DEF_NUM_CH = 2;
    localparam int DEF_FRAC_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Largest / smallest value of a signed number of width w.
    function automatic longint sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    localparam longint SAT_MAX = sat_max(2 * DEF_DATA_W);
    localparam longint SAT_MIN = sat_min(2 * DEF_DATA_W);

endpackage

// File: rtl/mat_add_lane.sv
// One matrix element: align B to A, add A+B+C, optionally add the accumulator,
// then saturate to the signed 2*DATA_W result range.
module mat_add_lane
    import mat_add_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int FRAC_W = DEF_FRAC_W
) (
    input  logic signed [DATA_W-1:0]   i_a,
    input  logic signed [DATA_W-1:0]   i_b,
    input  logic signed [2*DATA_W-1:0] i_c,
    input  logic signed [2*DATA_W-1:0] i_acc,
    input  logic                       i_intMode,
    input  logic                       i_accMode,
    output logic [2*DATA_W-1:0]        o_res
);

    localparam int RES_W = 2 * DATA_W;
    localparam int SUM_W = RES_W + 2;
    localparam int TOT_W = SUM_W + 1;
    localparam logic signed [TOT_W-1:0] MAXV = TOT_W'(sat_max(RES_W));
    localparam logic signed [TOT_W-1:0] MINV = TOT_W'(sat_min(RES_W));

    logic signed [SUM_W-1:0] w_aExt;
    logic signed [SUM_W-1:0] w_bExt;
    logic signed [SUM_W-1:0] w_cExt;
    logic signed [SUM_W-1:0] w_sum;
    logic signed [TOT_W-1:0] w_tot;

    // The accumulator is added to the unsaturated sum so only one clamp is applied.
    always_comb begin
        w_aExt = {{(SUM_W-DATA_W){i_a[DATA_W-1]}}, i_a};
        w_bExt = {{(SUM_W-DATA_W){i_b[DATA_W-1]}}, i_b};
        if (i_intMode) begin
            w_bExt = w_bExt <<< FRAC_W;
        end
        w_cExt = {{2{i_c[RES_W-1]}}, i_c};
        w_sum  = w_aExt + w_bExt + w_cExt;
        w_tot  = {w_sum[SUM_W-1], w_sum};
        if (i_accMode) begin
            w_tot = w_tot + {{3{i_acc[RES_W-1]}}, i_acc};
        end
        if (w_tot > MAXV) begin
            o_res = MAXV[RES_W-1:0];
        end else if (w_tot < MINV) begin
            o_res = MINV[RES_W-1:0];
        end else begin
            o_res = w_tot[RES_W-1:0];
        end
    end

endmodule

// File: rtl/mat_add_stream.sv
// Streams an N-row matrix frame through a two-stage element-wise adder with
// per-channel accumulators and a valid/ready handshake on both sides.
module mat_add_stream
    import mat_add_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int N      = DEF_N,
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int FRAC_W = DEF_FRAC_W
) (
    input  logic                              clk,
    input  logic                              _reset,
    input  logic                              start,
    input  logic                              int_mode,
    input  logic                              acc_mode,
    input  logic                              flush_acc,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [N*DATA_W-1:0]               a_row,
    input  logic [NUM_CH*N*DATA_W-1:0]        b_row,
    input  logic [NUM_CH*N*2*DATA_W-1:0]      c_row,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [NUM_CH*N*2*DATA_W-1:0]      out_row,
    output logic [$clog2(N)-1:0]              out_row_idx,
    output logic                              frame_done,
    output logic                              busy
);

    localparam int RES_W = 2 * DATA_W;
    localparam int ROW_W = NUM_CH * N * RES_W;
    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_t r_state;
    state_t w_nextState;

    logic                        r_intMode;
    logic                        r_accMode;
    logic                        r_flushPend;
    logic [IDX_W-1:0]            r_inIdx;
    logic                        r_s1Valid;
    logic [IDX_W-1:0]            r_s1Idx;
    logic [N*DATA_W-1:0]         r_a;
    logic [NUM_CH*N*DATA_W-1:0]  r_b;
    logic [ROW_W-1:0]            r_c;
    logic                        r_outValid;
    logic [IDX_W-1:0]            r_outIdx;
    logic [ROW_W-1:0]            r_outRow;
    logic [ROW_W-1:0]            r_acc [N];

    logic             w_stall;
    logic             w_inFire;
    logic             w_outFire;
    logic             w_doFlush;
    logic [ROW_W-1:0] w_accRow;
    logic [ROW_W-1:0] w_res;

    assign w_stall     = r_outValid && !out_ready;
    assign in_ready    = (r_state == ST_RUN) && !w_stall;
    assign w_inFire    = in_valid && in_ready;
    assign w_outFire   = r_outValid && out_ready;
    assign w_doFlush   = (r_state == ST_IDLE) && (flush_acc || r_flushPend);
    assign w_accRow    = r_acc[r_s1Idx];
    assign out_valid   = r_outValid;
    assign out_row     = r_outRow;
    assign out_row_idx = r_outIdx;
    assign frame_done  = w_outFire && (r_outIdx == LAST_IDX);
    assign busy        = (r_state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_nextState = ST_RUN;
            ST_RUN:   if (w_inFire && (r_inIdx == LAST_IDX)) w_nextState = ST_DRAIN;
            ST_DRAIN: if (frame_done) w_nextState = ST_IDLE;
            default:  w_nextState = ST_IDLE;
        endcase
    end

    // A flush requested mid-frame waits for IDLE so the running frame sees the old sums.
    always_ff @(posedge clk) begin
        if (_reset) begin
            r_intMode   <= 1'b0;
            r_accMode   <= 1'b0;
            r_flushPend <= 1'b0;
            r_inIdx     <= '0;
        end else begin
            if ((r_state == ST_IDLE) && start) begin
                r_intMode <= int_mode;
                r_accMode <= acc_mode;
            end
            if (w_doFlush) begin
                r_flushPend <= 1'b0;
            end else if (flush_acc && (r_state != ST_IDLE)) begin
                r_flushPend <= 1'b1;
            end
            if (w_inFire) begin
                r_inIdx <= (r_inIdx == LAST_IDX) ? '0 : r_inIdx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (_reset) begin
            r_s1Valid  <= 1'b0;
            r_s1Idx    <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_c        <= '0;
            r_outValid <= 1'b0;
            r_outIdx   <= '0;
            r_outRow   <= '0;
        end else if (!w_stall) begin
            r_s1Valid  <= w_inFire;
            r_outValid <= r_s1Valid;
            if (w_inFire) begin
                r_s1Idx <= r_inIdx;
                r_a     <= a_row;
                r_b     <= b_row;
                r_c     <= c_row;
            end
            if (r_s1Valid) begin
                r_outIdx <= r_s1Idx;
                r_outRow <= w_res;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (_reset || w_doFlush) begin
            for (int i = 0; i < N; i++) begin
                r_acc[i] <= '0;
            end
        end else if (w_outFire && r_accMode) begin
            r_acc[r_outIdx] <= r_outRow;
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        for (genvar col = 0; col < N; col++) begin : g_col
            localparam int E = ch * N + col;
            mat_add_lane #(
                .DATA_W (DATA_W),
                .FRAC_W (FRAC_W)
            ) u_lane (
                .i_a       (r_a[col*DATA_W +: DATA_W]),
                .i_b       (r_b[E*DATA_W +: DATA_W]),
                .i_c       (r_c[E*RES_W +: RES_W]),
                .i_acc     (w_accRow[E*RES_W +: RES_W]),
                .i_intMode (r_intMode),
                .i_accMode (r_accMode),
                .o_res     (w_res[E*RES_W +: RES_W])
            );
        end
    end

endmodule

// File: tb/tb_mat_add_stream.sv
// Bench for mat_add_stream: fixed vectors, accumulate/flush/reset sequences and
// random frames checked against an integer-arithmetic model of the element rules.
module tb_mat_add_stream;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         intMode = 1'b0;
    logic         accMode = 1'b0;
    logic         flushAcc = 1'b0;
    logic         inValid = 1'b0;
    logic         inReady;
    logic [31:0]  aRow = '0;
    logic [63:0]  bRow = '0;
    logic [127:0] cRow = '0;
    logic         outValid;
    logic         outReady = 1'b1;
    logic [127:0] outRow;
    logic [1:0]   outRowIdx;
    logic         frameDone;
    logic         busy;

    int nCompared = 0;
    int nMismatch = 0;

    logic [31:0]  fa [4];
    logic [63:0]  fb [4];
    logic [127:0] fc [4];
    logic [127:0] expRow [4];
    int           mAcc [2][4][4];

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] c;
        bit          im;
        logic [15:0] expv;
    } vec_t;
    vec_t vecs [8];

    mat_add_stream dut (
        .clk         (clk),
        ._reset      (reset),
        .start       (start),
        .int_mode    (intMode),
        .acc_mode    (accMode),
        .flush_acc   (flushAcc),
        .in_valid    (inValid),
        .in_ready    (inReady),
        .a_row       (aRow),
        .b_row       (bRow),
        .c_row       (cRow),
        .out_valid   (outValid),
        .out_ready   (outReady),
        .out_row     (outRow),
        .out_row_idx (outRowIdx),
        .frame_done  (frameDone),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] expv);
        nCompared++;
        if (act !== expv) begin
            nMismatch++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Element rule in plain integer arithmetic: alignment is a multiply by 2^FRAC_W.
    function automatic logic [15:0] refElem(input logic [7:0] a, input logic [7:0] b,
                                            input logic [15:0] c, input int acc,
                                            input bit im, input bit am);
        int s;
        int bv;
        bv = $signed(b);
        if (im) bv = bv * 16;
        s = int'($signed(a)) + bv + int'($signed(c));
        if (am) s = s + acc;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return s[15:0];
    endfunction

    task automatic zeroAcc();
        for (int ch = 0; ch < 2; ch++)
            for (int r = 0; r < 4; r++)
                for (int col = 0; col < 4; col++)
                    mAcc[ch][r][col] = 0;
    endtask

    task automatic buildExpected(input bit im, input bit am);
        logic [15:0] v;
        for (int r = 0; r < 4; r++) begin
            for (int ch = 0; ch < 2; ch++) begin
                for (int col = 0; col < 4; col++) begin
                    v = refElem(fa[r][col*8 +: 8], fb[r][(ch*4+col)*8 +: 8],
                                fc[r][(ch*4+col)*16 +: 16], mAcc[ch][r][col], im, am);
                    expRow[r][(ch*4+col)*16 +: 16] = v;
                    if (am) mAcc[ch][r][col] = int'($signed(v));
                end
            end
        end
    endtask

    task automatic fillBroadcast(input logic [7:0] a, input logic [7:0] b, input logic [15:0] c);
        for (int r = 0; r < 4; r++) begin
            fa[r] = {4{a}};
            fb[r] = {8{b}};
            fc[r] = {8{c}};
        end
    endtask

    // Runs one frame from a negedge; returns at the negedge after the last output handshake.
    task automatic applyStimulus(input bit im, input bit am, input int stallLen,
                                 input int flushAt, input bit chkLat);
        int nextIn = 0;
        int nextOut = 0;
        int cyc = 0;
        int acc0Cyc = -1;
        int firstOutCyc = -1;
        int doneCnt = 0;
        int stallLeft = stallLen;
        bit wasStalled = 0;
        logic [127:0] heldRow;
        logic [1:0] heldIdx;
        start = 1'b1;
        intMode = im;
        accMode = am;
        @(negedge clk);
        start = 1'b0;
        intMode = ~im;
        accMode = ~am;
        while (nextOut < 4 && cyc < 100) begin
            start = (cyc == 1);
            flushAcc = (cyc == flushAt);
            outReady = !(outValid && stallLeft > 0);
            if (!outReady) stallLeft--;
            inValid = (nextIn < 4);
            if (nextIn < 4) begin
                aRow = fa[nextIn];
                bRow = fb[nextIn];
                cRow = fc[nextIn];
            end
            #1;
            if (cyc == 0) checkOutput("busy_in_frame", busy, 1);
            if (wasStalled) begin
                checkOutput("stall_hold_row", outRow, heldRow);
                checkOutput("stall_hold_idx", outRowIdx, heldIdx);
            end
            if (outValid && !outReady) begin
                checkOutput("stall_in_ready", inReady, 0);
                heldRow = outRow;
                heldIdx = outRowIdx;
                wasStalled = 1;
            end else begin
                wasStalled = 0;
            end
            if (outValid && firstOutCyc < 0) firstOutCyc = cyc;
            if (inValid && inReady) begin
                if (nextIn == 0) acc0Cyc = cyc;
                nextIn++;
            end
            if (frameDone) doneCnt++;
            if (outValid && outReady) begin
                checkOutput("row_data", outRow, expRow[nextOut]);
                checkOutput("row_idx", outRowIdx, nextOut);
                checkOutput("frame_done_at_fire", frameDone, nextOut == 3);
                nextOut++;
            end
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        inValid = 1'b0;
        flushAcc = 1'b0;
        outReady = 1'b1;
        checkOutput("rows_out_in_budget", nextOut, 4);
        checkOutput("frame_done_count", doneCnt, 1);
        if (chkLat) checkOutput("latency", firstOutCyc - acc0Cyc, 2);
        checkOutput("busy_after_frame", busy, 0);
        if (flushAt >= 0) zeroAcc();
    endtask

    task automatic doIdleFlush();
        flushAcc = 1'b1;
        @(negedge clk);
        flushAcc = 1'b0;
        zeroAcc();
    endtask

    task automatic resetMidFrame();
        int accepted = 0;
        int cyc = 0;
        fillBroadcast(8'h01, 8'h01, 16'h0000);
        start = 1'b1;
        accMode = 1'b1;
        intMode = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (accepted < 2 && cyc < 20) begin
            inValid = 1'b1;
            aRow = fa[accepted];
            bRow = fb[accepted];
            cRow = fc[accepted];
            #1;
            if (inReady) accepted++;
            cyc++;
            @(negedge clk);
        end
        inValid = 1'b0;
        checkOutput("rows_before_reset", accepted, 2);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("mid_reset_busy", busy, 0);
        checkOutput("mid_reset_out_valid", outValid, 0);
        checkOutput("mid_reset_in_ready", inReady, 0);
        checkOutput("mid_reset_idx", outRowIdx, 0);
        reset = 1'b0;
        zeroAcc();
    endtask

    initial begin
        vecs[0] = '{8'h18, 8'h02, 16'h0000, 1'b1, 16'h0038};
        vecs[1] = '{8'hFD, 8'h05, 16'h0010, 1'b0, 16'h0012};
        vecs[2] = '{8'h7F, 8'h7F, 16'h7FFF, 1'b0, 16'h7FFF};
        vecs[3] = '{8'h80, 8'h80, 16'h8000, 1'b0, 16'h8000};
        vecs[4] = '{8'h80, 8'h80, 16'h8000, 1'b1, 16'h8000};
        vecs[5] = '{8'h7F, 8'h7F, 16'h7F00, 1'b1, 16'h7FFF};
        vecs[6] = '{8'h01, 8'hFF, 16'h0000, 1'b1, 16'hFFF1};
        vecs[7] = '{8'h00, 8'h00, 16'h1234, 1'b0, 16'h1234};
        zeroAcc();

        repeat (3) @(negedge clk);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_in_ready", inReady, 0);
        checkOutput("reset_out_valid", outValid, 0);
        checkOutput("reset_out_row", outRow, 0);
        checkOutput("reset_idx", outRowIdx, 0);
        checkOutput("reset_frame_done", frameDone, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            fillBroadcast(vecs[i].a, vecs[i].b, vecs[i].c);
            for (int r = 0; r < 4; r++) expRow[r] = {8{vecs[i].expv}};
            applyStimulus(vecs[i].im, 1'b0, 0, -1, 1'b1);
        end

        fillBroadcast(8'h01, 8'h01, 16'h0000);
        buildExpected(1'b0, 1'b1);
        checkOutput("model_acc_frame1", expRow[0][15:0], 16'h0002);
        applyStimulus(1'b0, 1'b1, 0, -1, 1'b1);
        buildExpected(1'b0, 1'b1);
        checkOutput("model_acc_frame2", expRow[0][15:0], 16'h0004);
        applyStimulus(1'b0, 1'b1, 0, -1, 1'b1);
        doIdleFlush();
        buildExpected(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 0, -1, 1'b1);

        for (int r = 0; r < 4; r++) begin
            fa[r] = $urandom;
            fb[r] = {$urandom, $urandom};
            fc[r] = {$urandom, $urandom, $urandom, $urandom};
        end
        buildExpected(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 5, -1, 1'b0);

        resetMidFrame();
        fillBroadcast(8'h01, 8'h01, 16'h0000);
        buildExpected(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 0, -1, 1'b1);

        buildExpected(1'b0, 1'b1);
        checkOutput("model_flush_run_old_acc", expRow[3][15:0], 16'h0004);
        applyStimulus(1'b0, 1'b1, 0, 2, 1'b1);
        buildExpected(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 0, -1, 1'b1);

        for (int k = 0; k < 10; k++) begin
            bit im;
            bit am;
            int stallLen;
            int flushAt;
            for (int r = 0; r < 4; r++) begin
                fa[r] = $urandom;
                fb[r] = {$urandom, $urandom};
                fc[r] = (k % 2 == 0) ? {8{16'($urandom_range(0, 255))}}
                                     : {$urandom, $urandom, $urandom, $urandom};
            end
            im = 1'($urandom_range(0, 1));
            am = 1'($urandom_range(0, 1));
            stallLen = $urandom_range(0, 3);
            flushAt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1;
            buildExpected(im, am);
            applyStimulus(im, am, stallLen, flushAt, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule

// File: doc/mat_add_stream.md
MAT_ADD_STREAM -- requirements
Module: mat_add_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand width; results are 2*DATA_W wide.
REQ-002 SHALL have parameter N, default 4, matrix dimension (N rows, N columns).
REQ-003 SHALL have parameter NUM_CH, default 2, number of parallel B/C result channels sharing one A operand.
REQ-004 SHALL have parameter FRAC_W, default 4, fractional bits of A in integer-alignment mode.
REQ-005 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-006 SHALL have port _reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have ports start (in, 1, frame start pulse), int_mode (in, 1, B is integer and is aligned to A), acc_mode (in, 1, accumulate across frames), flush_acc (in, 1, clear accumulators).
REQ-008 SHALL have ports in_valid (in, 1), in_ready (out, 1), a_row (in, N*DATA_W), b_row (in, NUM_CH*N*DATA_W), c_row (in, NUM_CH*N*2*DATA_W); all signed, column 0 in the LSBs, channel 0 lowest.
REQ-009 SHALL have ports out_valid (out, 1), out_ready (in, 1), out_row (out, NUM_CH*N*2*DATA_W), out_row_idx (out, clog2(N)), frame_done (out, 1), busy (out, 1).

Function
REQ-010 Per element: sum = sext(a) + (int_mode ? sext(b)<<FRAC_W : sext(b)) + c; computed at 2*DATA_W+2 bits; saturated to the signed 2*DATA_W range.
REQ-011 In acc_mode: out = sat(sum + acc[ch][row][col]); acc entry SHALL be written with out on the output handshake; non-acc mode leaves acc untouched.
REQ-012 FSM states IDLE, RUN, DRAIN; IDLE->RUN on start; RUN->DRAIN on acceptance of row N-1; DRAIN->IDLE on output handshake of row N-1.
REQ-013 int_mode and acc_mode SHALL be latched at start; changes mid-frame are ignored; start outside IDLE is ignored.
REQ-014 Input handshake: row accepted when in_valid && in_ready; in_ready = (state==RUN) && !stall; stall = out_valid && !out_ready.
REQ-015 Two-stage pipeline (operand register, result register); out_valid rises 2 cycles after acceptance when not stalled; the whole pipeline freezes during stall.
REQ-016 While out_valid && !out_ready, out_row and out_row_idx SHALL hold stable; no row is dropped or duplicated.
REQ-017 out_row_idx SHALL equal 0..N-1 in acceptance order, wrapping to 0 for the next frame.
REQ-018 frame_done SHALL pulse high exactly one cycle, in the cycle of the row N-1 output handshake.
REQ-019 busy = (state != IDLE).
REQ-020 flush_acc in IDLE clears all accumulators next cycle; flush_acc in RUN/DRAIN is held pending and applied on the cycle after the return to IDLE; start and pending flush in the same IDLE cycle: flush first, frame uses zero acc.

Reset
REQ-021 On _reset: state IDLE, in_ready 0, out_valid 0, out_row 0, out_row_idx 0, frame_done 0, busy 0, all accumulators 0, pending flush cleared; reset overrides every other input including mid-frame.

Structure
REQ-022 Shared package mat_add_pkg SHALL hold default DATA_W/N/NUM_CH/FRAC_W, FSM state encoding, and saturation limit constants.
REQ-023 Sub-module mat_add_lane SHALL implement one element (align, 3-input add, optional acc add, saturate), instantiated NUM_CH*N times.

Verification (defaults, out_ready=1 unless stated)
REQ-024 int_mode=1, all a=0x18, b=0x02, c=0 -> every out element 0x0038, latency 2 cycles.
REQ-025 int_mode=0, a=0xFD, b=0x05, c=0x0010 -> 0x0012; a=b=0x7F, c=0x7FFF -> 0x7FFF; a=b=0x80, c=0x8000 -> 0x8000.
REQ-026 acc_mode=1, a=b=1, c=0, two frames -> frame 1 outputs 0x0002, frame 2 outputs 0x0004; flush_acc in IDLE then third frame -> 0x0002.
REQ-027 out_ready=0 for 5 cycles after first out_valid -> out_row stable, in_ready=0, rows out with idx 0,1,2,3, single frame_done pulse.
REQ-028 _reset asserted after 2 rows accepted -> next cycle busy=0, out_valid=0, acc zero; new start runs a clean frame.
REQ-029 flush_acc asserted during RUN in acc_mode -> current frame uses old acc; following frame sees zeroed acc.
